ila_readout_ctrl: RTL and testbench

- Readout sequencer for the ILA sample buffer, in the system clock domain.
- Snapshots the sample count and walks buffer indices and part selects through the INDEX / value_select write ports.
- Waits for the registered read value and emits one AXI-Stream beat per DATA_W word, with tlast on the final word.
- Replaces software polling of INDEX/value for bulk capture dumps.

---
 rtl/ila_readout_ctrl_pkg.sv | 18 +
 rtl/ila_readout_ctrl_if.sv | 39 +++
 rtl/ila_readout_beat.sv | 48 ++++
 rtl/ila_readout_ctrl.sv | 144 ++++++++++++++
 tb/tb_ila_readout_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ila_readout_ctrl_pkg.sv
// Shared types for the ILA readout sequencer: FSM encoding and counter sizing.
package ila_readout_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StSend  = 2'd3
  } state_e;

  // Sample counters need one extra bit so a full circular buffer (2^BUFFER_W) fits.
  function automatic int unsigned cnt_width(input int unsigned buffer_w);
    return buffer_w + 1;
  endfunction

endpackage

// File: rtl/ila_readout_ctrl_if.sv
// Control, buffer-port and AXI-Stream signals of the readout sequencer.
// Signal names keep the sequencer's point of view (_i into it, _o out of it).
interface ila_readout_ctrl_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BUFFER_W = 10,
  parameter int unsigned SEL_W    = 4
);

  logic                start_i;
  logic                abort_i;
  logic                circular_i;
  logic [BUFFER_W-1:0] samples_i;
  logic                busy_o;
  logic                done_o;

  logic                index_wen_o;
  logic [BUFFER_W-1:0] index_wdata_o;
  logic                sel_wen_o;
  logic [SEL_W-1:0]    sel_wdata_o;
  logic [DATA_W-1:0]   value_i;

  logic [DATA_W-1:0]   m_tdata_o;
  logic                m_tvalid_o;
  logic                m_tready_i;
  logic                m_tlast_o;

  modport master (
    input  start_i, abort_i, circular_i, samples_i, value_i, m_tready_i,
    output busy_o, done_o, index_wen_o, index_wdata_o, sel_wen_o, sel_wdata_o,
    output m_tdata_o, m_tvalid_o, m_tlast_o
  );

  modport slave (
    output start_i, abort_i, circular_i, samples_i, value_i, m_tready_i,
    input  busy_o, done_o, index_wen_o, index_wdata_o, sel_wen_o, sel_wdata_o,
    input  m_tdata_o, m_tvalid_o, m_tlast_o
  );

endinterface

// File: rtl/ila_readout_beat.sv
// Single-entry stream output register: holds tdata/tlast with tvalid until the
// ready handshake. Shared with the DMA readout path.
module ila_readout_beat #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              tready_i,
  output logic [DATA_W-1:0] tdata_o,
  output logic              tvalid_o,
  output logic              tlast_o,
  output logic              fire_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (cke_i) begin
      if (load_i) begin
        data_q  <= data_i;
        last_q  <= last_i;
        valid_q <= 1'b1;
      end else if (valid_q && tready_i) begin
        // Data is left in place; only the qualifiers drop after the handshake.
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    tdata_o  = data_q;
    tvalid_o = valid_q;
    tlast_o  = last_q;
    fire_o   = valid_q && tready_i;
  end

endmodule

// File: rtl/ila_readout_ctrl.sv
// ILA buffer readout sequencer: walks (index, part) through the buffer write ports,
// waits out the read latency and streams one word per beat with tlast on the final word.
module ila_readout_ctrl
  import ila_readout_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BUFFER_W = 10,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned PARTS    = 2,
  parameter int unsigned READ_LAT = 3
) (
  input logic                clk_i,
  input logic                arst_n_i,
  input logic                cke_i,
  ila_readout_ctrl_if.master bus
);

  localparam int unsigned CntW = cnt_width(BUFFER_W);
  localparam int unsigned LatW = $clog2(READ_LAT + 1);

  state_e              state_q, state_d;
  logic [BUFFER_W-1:0] base_q;
  logic [CntW-1:0]     total_q;
  logic [CntW-1:0]     k_q;
  logic [SEL_W-1:0]    p_q;
  logic [LatW-1:0]     lat_q;
  logic                abort_q;
  logic                done_q;

  logic [CntW-1:0]     plan_total;
  logic                fetch_done;
  logic                last_part;
  logic                beat_last;
  logic                fire;
  logic                dump_end;
  logic [DATA_W-1:0]   tdata;
  logic                tvalid;
  logic                tlast;

  always_comb begin
    plan_total = bus.circular_i ? {1'b1, {BUFFER_W{1'b0}}} : {1'b0, bus.samples_i};
    fetch_done = (state_q == StWait) && (lat_q == LatW'(1));
    last_part  = (p_q == SEL_W'(PARTS - 1));
    beat_last  = (k_q == total_q - CntW'(1)) && last_part;
    // An abort arriving on the handshake cycle itself also ends the dump here.
    dump_end   = fire && (tlast || abort_q || bus.abort_i);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= StIdle;
    end else if (cke_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start_i && (plan_total != '0)) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (fetch_done) state_d = StSend;
      StSend:  if (fire) state_d = dump_end ? StIdle : StIssue;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.index_wen_o   = (state_q == StIssue);
    bus.sel_wen_o     = (state_q == StIssue);
    bus.index_wdata_o = (state_q == StIssue) ? base_q + k_q[BUFFER_W-1:0] : '0;
    bus.sel_wdata_o   = (state_q == StIssue) ? p_q : '0;
    bus.busy_o        = (state_q != StIdle);
    bus.done_o        = done_q;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      base_q  <= '0;
      total_q <= '0;
      k_q     <= '0;
      p_q     <= '0;
      lat_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (cke_i) begin
      done_q <= 1'b0;
      if ((state_q != StIdle) && bus.abort_i) begin
        abort_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (bus.start_i) begin
            base_q  <= bus.circular_i ? bus.samples_i : '0;
            total_q <= plan_total;
            k_q     <= '0;
            p_q     <= '0;
            done_q  <= (plan_total == '0);
          end
        end
        StIssue: lat_q <= LatW'(READ_LAT);
        StWait:  lat_q <= lat_q - LatW'(1);
        StSend: begin
          if (dump_end) begin
            done_q  <= 1'b1;
            abort_q <= 1'b0;
          end else if (fire) begin
            if (last_part) begin
              p_q <= '0;
              k_q <= k_q + CntW'(1);
            end else begin
              p_q <= p_q + SEL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  ila_readout_beat #(
    .DATA_W (DATA_W)
  ) u_beat (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .load_i   (fetch_done),
    .data_i   (bus.value_i),
    .last_i   (beat_last),
    .tready_i (bus.m_tready_i),
    .tdata_o  (tdata),
    .tvalid_o (tvalid),
    .tlast_o  (tlast),
    .fire_o   (fire)
  );

  always_comb begin
    bus.m_tdata_o  = tdata;
    bus.m_tvalid_o = tvalid;
    bus.m_tlast_o  = tlast;
  end

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// Directed bench: a linear-mode instance (PARTS=2) and a circular-mode instance (PARTS=1),
// each fed by a READ_LAT-deep registered buffer model.
module tb_ila_readout_ctrl;

  localparam int RL = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic cke = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ila_readout_ctrl_if #(.DATA_W(32), .BUFFER_W(4), .SEL_W(4)) a_if ();
  ila_readout_ctrl_if #(.DATA_W(32), .BUFFER_W(3), .SEL_W(4)) b_if ();

  ila_readout_ctrl #(
    .DATA_W(32), .BUFFER_W(4), .SEL_W(4), .PARTS(2), .READ_LAT(RL)
  ) u_dut_a (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .bus(a_if)
  );

  ila_readout_ctrl #(
    .DATA_W(32), .BUFFER_W(3), .SEL_W(4), .PARTS(1), .READ_LAT(RL)
  ) u_dut_b (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .bus(b_if)
  );

  function automatic logic [31:0] exp_word(input int idx, input int sel);
    return 32'hC0DE_0000 | 32'(idx << 8) | 32'(sel);
  endfunction

  // Buffer models: address registered on the write strobe, then RL-1 more stages.
  int a_pidx [RL];
  int a_psel [RL];
  int b_pidx [RL];
  int b_psel [RL];
  assign a_if.value_i = exp_word(a_pidx[RL-1], a_psel[RL-1]);
  assign b_if.value_i = exp_word(b_pidx[RL-1], b_psel[RL-1]);

  int          a_idx[$], a_sel[$], a_bcyc[$], a_done[$];
  logic [31:0] a_data[$];
  logic        a_last[$];
  int          b_idx[$], b_done[$];
  logic [31:0] b_data[$];
  logic        b_last[$];

  always @(posedge clk) begin
    if (arst_n && cke) begin
      if (a_if.index_wen_o) begin
        a_idx.push_back(int'(a_if.index_wdata_o));
        a_sel.push_back(int'(a_if.sel_wdata_o));
        a_pidx[0] <= int'(a_if.index_wdata_o);
        a_psel[0] <= int'(a_if.sel_wdata_o);
      end
      if (b_if.index_wen_o) begin
        b_idx.push_back(int'(b_if.index_wdata_o));
        b_pidx[0] <= int'(b_if.index_wdata_o);
        b_psel[0] <= int'(b_if.sel_wdata_o);
      end
      for (int i = 1; i < RL; i++) begin
        a_pidx[i] <= a_pidx[i-1];
        a_psel[i] <= a_psel[i-1];
        b_pidx[i] <= b_pidx[i-1];
        b_psel[i] <= b_psel[i-1];
      end
      if (a_if.m_tvalid_o && a_if.m_tready_i) begin
        a_data.push_back(a_if.m_tdata_o);
        a_last.push_back(a_if.m_tlast_o);
        a_bcyc.push_back(cyc);
      end
      if (b_if.m_tvalid_o && b_if.m_tready_i) begin
        b_data.push_back(b_if.m_tdata_o);
        b_last.push_back(b_if.m_tlast_o);
      end
      if (a_if.done_o) a_done.push_back(cyc);
      if (b_if.done_o) b_done.push_back(cyc);
    end
  end

  task automatic clear_a();
    a_idx.delete(); a_sel.delete(); a_bcyc.delete(); a_done.delete();
    a_data.delete(); a_last.delete();
  endtask

  task automatic start_a(input bit circ, input int n);
    @(negedge clk);
    a_if.circular_i = circ;
    a_if.samples_i  = 4'(n);
    a_if.start_i    = 1'b1;
    @(negedge clk);
    a_if.start_i    = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    for (int n = 0; n < 400 && a_done.size() == 0; n++) @(negedge clk);
    checks++;
    if (a_done.size() == 0) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done pulse, want one", tag);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    a_if.start_i = 0; a_if.abort_i = 0; a_if.circular_i = 0; a_if.samples_i = '0;
    a_if.m_tready_i = 1;
    b_if.start_i = 0; b_if.abort_i = 0; b_if.circular_i = 0; b_if.samples_i = '0;
    b_if.m_tready_i = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_if.m_tvalid_o, a_if.m_tlast_o, a_if.busy_o, a_if.done_o, a_if.index_wen_o,
         a_if.sel_wen_o} !== 6'b0 || a_if.m_tdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_in: got valid=%b last=%b busy=%b done=%b wen=%b data=%h, want 0",
               a_if.m_tvalid_o, a_if.m_tlast_o, a_if.busy_o, a_if.done_o,
               a_if.index_wen_o, a_if.m_tdata_o);
    end
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_if.busy_o, a_if.m_tvalid_o, a_if.index_wdata_o, a_if.sel_wdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_out: got busy=%b valid=%b idx=%0d sel=%0d, want 0",
               a_if.busy_o, a_if.m_tvalid_o, a_if.index_wdata_o, a_if.sel_wdata_o);
    end
  endtask

  task automatic test_linear();
    clear_a();
    start_a(0, 4);
    wait_done_a("linear");
    checks++;
    if (a_data.size() != 8 || a_idx.size() != 8) begin
      errors++;
      $display("FAIL linear_count: got beats=%0d writes=%0d, want 8/8", a_data.size(), a_idx.size());
    end
    for (int i = 0; i < 8 && i < a_data.size() && i < a_idx.size(); i++) begin
      checks++;
      if (a_idx[i] != i / 2 || a_sel[i] != i % 2) begin
        errors++;
        $display("FAIL linear_addr%0d: got idx=%0d sel=%0d, want %0d/%0d",
                 i, a_idx[i], a_sel[i], i / 2, i % 2);
      end
      checks++;
      if (a_data[i] !== exp_word(i / 2, i % 2) || a_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL linear_beat%0d: got data=%h last=%b, want %h/%b",
                 i, a_data[i], a_last[i], exp_word(i / 2, i % 2), i == 7);
      end
    end
    checks++;
    if (a_done.size() != 1 || a_bcyc.size() != 8 || a_done[0] != a_bcyc[7] + 1) begin
      errors++;
      $display("FAIL linear_done: got %0d pulses, want one pulse right after the last beat",
               a_done.size());
    end
    checks++;
    if (a_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL linear_idle: got busy=%b want 0", a_if.busy_o);
    end
  endtask

  task automatic test_circular();
    @(negedge clk);
    b_if.circular_i = 1; b_if.samples_i = 3'd6; b_if.start_i = 1;
    @(negedge clk);
    b_if.start_i = 0;
    for (int n = 0; n < 200 && b_done.size() == 0; n++) @(negedge clk);
    checks++;
    if (b_data.size() != 8 || b_idx.size() != 8 || b_done.size() != 1) begin
      errors++;
      $display("FAIL circ_count: got beats=%0d writes=%0d done=%0d, want 8/8/1",
               b_data.size(), b_idx.size(), b_done.size());
    end
    for (int i = 0; i < 8 && i < b_data.size() && i < b_idx.size(); i++) begin
      checks++;
      if (b_idx[i] != (6 + i) % 8 || b_data[i] !== exp_word((6 + i) % 8, 0) ||
          b_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL circ_beat%0d: got idx=%0d data=%h last=%b, want %0d/%h/%b", i, b_idx[i],
                 b_data[i], b_last[i], (6 + i) % 8, exp_word((6 + i) % 8, 0), i == 7);
      end
    end
  endtask

  task automatic test_empty();
    clear_a();
    @(negedge clk);
    a_if.circular_i = 0; a_if.samples_i = '0; a_if.start_i = 1;
    @(negedge clk);
    a_if.start_i = 0;
    checks++;
    if (a_if.done_o !== 1'b1 || a_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_pulse: got done=%b busy=%b, want 1/0", a_if.done_o, a_if.busy_o);
    end
    @(negedge clk);
    checks++;
    if (a_if.done_o !== 1'b0 || a_if.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got done=%b busy=%b, want 0/0", a_if.done_o, a_if.busy_o);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (a_idx.size() != 0 || a_data.size() != 0 || a_done.size() != 1) begin
      errors++;
      $display("FAIL empty_quiet: got writes=%0d beats=%0d done=%0d, want 0/0/1",
               a_idx.size(), a_data.size(), a_done.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic        l;
    int          ni;
    clear_a();
    start_a(0, 4);
    for (int n = 0; n < 100 && a_data.size() < 3; n++) @(negedge clk);
    a_if.m_tready_i = 0;
    for (int n = 0; n < 100 && a_if.m_tvalid_o !== 1'b1; n++) @(negedge clk);
    d  = a_if.m_tdata_o;
    l  = a_if.m_tlast_o;
    ni = a_idx.size();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (a_if.m_tvalid_o !== 1'b1 || a_if.m_tdata_o !== d || a_if.m_tlast_o !== l ||
          a_idx.size() != ni) begin
        errors++;
        $display("FAIL bp_stall%0d: got valid=%b data=%h writes=%0d, want 1/%h/%0d",
                 c, a_if.m_tvalid_o, a_if.m_tdata_o, a_idx.size(), d, ni);
      end
    end
    a_if.m_tready_i = 1;
    wait_done_a("bp");
    checks++;
    if (a_data.size() != 8) begin
      errors++;
      $display("FAIL bp_count: got beats=%0d want 8", a_data.size());
    end
    for (int i = 0; i < 8 && i < a_data.size(); i++) begin
      checks++;
      if (a_data[i] !== exp_word(i / 2, i % 2) || a_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL bp_beat%0d: got data=%h last=%b, want %h/%b",
                 i, a_data[i], a_last[i], exp_word(i / 2, i % 2), i == 7);
      end
    end
  endtask

  task automatic test_abort();
    clear_a();
    start_a(0, 4);
    for (int n = 0; n < 100 && a_idx.size() < 3; n++) @(negedge clk);
    a_if.abort_i = 1;
    @(negedge clk);
    a_if.abort_i = 0;
    wait_done_a("abort");
    checks++;
    if (a_data.size() != 3 || a_idx.size() != 3) begin
      errors++;
      $display("FAIL abort_count: got beats=%0d writes=%0d, want 3/3", a_data.size(), a_idx.size());
    end else begin
      checks++;
      if (a_data[2] !== exp_word(1, 0) || a_last[2] !== 1'b0 || a_done[0] != a_bcyc[2] + 1) begin
        errors++;
        $display("FAIL abort_beat3: got data=%h last=%b, want %h/0 and done right after",
                 a_data[2], a_last[2], exp_word(1, 0));
      end
    end
    clear_a();
    start_a(0, 2);
    wait_done_a("restart");
    checks++;
    if (a_data.size() != 4 || a_data[3] !== exp_word(1, 1) || a_last[3] !== 1'b1) begin
      errors++;
      $display("FAIL restart: got beats=%0d, want 4 ending in %h with tlast",
               a_data.size(), exp_word(1, 1));
    end
  endtask

  task automatic test_cke();
    clear_a();
    a_if.m_tready_i = 0;
    start_a(0, 1);
    for (int n = 0; n < 100 && a_if.m_tvalid_o !== 1'b1; n++) @(negedge clk);
    cke = 0;
    a_if.m_tready_i = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_if.m_tvalid_o !== 1'b1 || a_if.busy_o !== 1'b1 || a_if.m_tdata_o !== exp_word(0, 0)) begin
      errors++;
      $display("FAIL cke_hold: got valid=%b busy=%b data=%h, want 1/1/%h",
               a_if.m_tvalid_o, a_if.busy_o, a_if.m_tdata_o, exp_word(0, 0));
    end
    cke = 1;
    wait_done_a("cke");
    checks++;
    if (a_data.size() != 2 || a_data[0] !== exp_word(0, 0)) begin
      errors++;
      $display("FAIL cke_resume: got beats=%0d, want 2", a_data.size());
    end
  endtask

  task automatic test_reset_mid();
    clear_a();
    a_if.m_tready_i = 0;
    start_a(0, 4);
    for (int n = 0; n < 100 && a_if.m_tvalid_o !== 1'b1; n++) @(negedge clk);
    arst_n = 0;
    #1;
    checks++;
    if ({a_if.m_tvalid_o, a_if.m_tlast_o, a_if.busy_o, a_if.done_o, a_if.index_wen_o} !== 5'b0 ||
        a_if.m_tdata_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_async: got valid=%b busy=%b data=%h, want 0/0/0",
               a_if.m_tvalid_o, a_if.busy_o, a_if.m_tdata_o);
    end
    @(negedge clk);
    arst_n = 1;
    a_if.m_tready_i = 1;
    repeat (4) @(negedge clk);
    checks++;
    if (a_if.busy_o !== 1'b0 || a_data.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_idle: got busy=%b beats=%0d, want 0/0", a_if.busy_o, a_data.size());
    end
    start_a(0, 1);
    wait_done_a("rst_restart");
    checks++;
    if (a_data.size() != 2 || a_last[1] !== 1'b1 || a_data[1] !== exp_word(0, 1)) begin
      errors++;
      $display("FAIL rst_restart: got beats=%0d, want 2 ending in %h", a_data.size(),
               exp_word(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_circular();
    test_empty();
    test_backpressure();
    test_abort();
    test_cke();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
